// File: rtl/dbus_arbiter_pkg.sv
// Shared data-bus request/response payload types for the dbus arbiter.
package dbus_arbiter_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned SIZE_W = 2;
   localparam int unsigned STRB_W = 4;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic [SIZE_W-1:0] size;
      logic [STRB_W-1:0] strobe;
      logic [DATA_W-1:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic              addr_ok;
      logic              data_ok;
      logic [DATA_W-1:0] data;
   } dbus_resp_t;

endpackage

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: shares one data bus between the fetch-side page walker and
// the memory stage. The winning request is latched and replayed to the bus
// until its data phase completes; abandoned requests are drained.
// Build option: define DBUS_ARB_RR_EN for round-robin tie breaking,
// otherwise the memory stage wins every tie.
module dbus_arbiter
   import dbus_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  dbus_req_t  freq,
   output dbus_resp_t fresp,
   input  dbus_req_t  mreq,
   output dbus_resp_t mresp,
   output dbus_req_t  oreq,
   input  dbus_resp_t oresp,
   output logic [1:0] owner
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT_F = 2'd1,
      S_GRANT_M = 2'd2,
      S_DRAIN   = 2'd3
   } state_t;

   state_t    r_state;
   state_t    w_state_nxt;
   dbus_req_t r_hold;
   logic      w_win_f;
   logic      w_win_m;

`ifdef DBUS_ARB_RR_EN
   // 1: fetch side wins the next tie, 0: memory side wins it
   logic r_ptr_f;

   // Round-robin winner selection among the valid requesters
   always_comb begin
      w_win_m = 1'b0;
      w_win_f = 1'b0;
      if (mreq.valid && freq.valid) begin
         w_win_f = r_ptr_f;
         w_win_m = ~r_ptr_f;
      end else begin
         w_win_m = mreq.valid;
         w_win_f = freq.valid;
      end
   end

   // Pointer moves to the requester that did not just win
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ptr_f <= 1'b0;
      end else if (r_state == S_IDLE) begin
         if (w_win_m) begin
            r_ptr_f <= 1'b1;
         end else if (w_win_f) begin
            r_ptr_f <= 1'b0;
         end
      end
   end
`else
   // Fixed priority: memory stage wins any tie
   always_comb begin
      w_win_m = mreq.valid;
      w_win_f = freq.valid & ~mreq.valid;
   end
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Capture the winner's full request so the bus never sees live inputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_hold <= '0;
      end else if (r_state == S_IDLE) begin
         if (w_win_m) begin
            r_hold <= mreq;
         end else if (w_win_f) begin
            r_hold <= freq;
         end
      end
   end

   // Next-state logic and bus/response routing
   always_comb begin
      w_state_nxt = r_state;
      oreq        = '0;
      fresp       = '0;
      mresp       = '0;
      owner       = 2'b00;
      case (r_state)
         S_IDLE: begin
            if (w_win_m) begin
               w_state_nxt = S_GRANT_M;
            end else if (w_win_f) begin
               w_state_nxt = S_GRANT_F;
            end
         end
         S_GRANT_F: begin
            oreq       = r_hold;
            oreq.valid = 1'b1;
            fresp      = oresp;
            owner      = 2'b01;
            if (oresp.data_ok) begin
               w_state_nxt = S_IDLE;
            end else if (!freq.valid) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_GRANT_M: begin
            oreq       = r_hold;
            oreq.valid = 1'b1;
            mresp      = oresp;
            owner      = 2'b10;
            if (oresp.data_ok) begin
               w_state_nxt = S_IDLE;
            end else if (!mreq.valid) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Finish the abandoned bus transaction; its response is dropped
            oreq       = r_hold;
            oreq.valid = 1'b1;
            if (oresp.data_ok) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Self-checking bench for dbus_arbiter with a scoreboard of expected grants.
module tb_dbus_arbiter;
   import dbus_arbiter_pkg::*;

   logic       clk;
   logic       reset;
   dbus_req_t  freq;
   dbus_req_t  mreq;
   dbus_req_t  oreq;
   dbus_resp_t fresp;
   dbus_resp_t mresp;
   dbus_resp_t oresp;
   logic [1:0] owner;

   typedef struct {
      logic [1:0]  who;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   n_cmp = 0;
   int   n_err = 0;

   dbus_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .freq  (freq),
      .fresp (fresp),
      .mreq  (mreq),
      .mresp (mresp),
      .oreq  (oreq),
      .oresp (oresp),
      .owner (owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic push_exp(input logic [1:0] who, input logic [31:0] addr, input logic [31:0] data);
      exp_t x;
      x.who  = who;
      x.addr = addr;
      x.data = data;
      exp_q.push_back(x);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      freq  = '0; freq.valid = 1'b1; freq.addr = 32'hDEAD_0000;
      mreq  = '0; mreq.valid = 1'b1; mreq.addr = 32'hBEEF_0000;
      oresp = '0; oresp.data_ok = 1'b1; oresp.data = 32'h1234_5678;
      tick(); tick(); settle();
      n_cmp++; if (oreq !== '0) begin n_err++; $display("FAIL reset_oreq: got %h want 0", oreq); end
      n_cmp++; if (owner !== 2'b00) begin n_err++; $display("FAIL reset_owner: got %b want 00", owner); end
      n_cmp++; if (fresp !== '0) begin n_err++; $display("FAIL reset_fresp: got %h want 0", fresp); end
      n_cmp++; if (mresp !== '0) begin n_err++; $display("FAIL reset_mresp: got %h want 0", mresp); end
      reset = 1'b1; freq = '0; mreq = '0; oresp = '0;
      tick();
   endtask

   task automatic test_fetch_only();
      freq = '0; freq.valid = 1'b1; freq.addr = 32'h8000_1000; freq.size = 2'd2;
      push_exp(2'b01, 32'h8000_1000, 32'h2000_0C01);
      settle();
      n_cmp++; if (owner !== 2'b00) begin n_err++; $display("FAIL fetch_idle_owner: got %b want 00", owner); end
      n_cmp++; if (oreq.valid !== 1'b0) begin n_err++; $display("FAIL fetch_idle_valid: got %b want 0", oreq.valid); end
      tick(); settle();
      e = exp_q.pop_front();
      n_cmp++; if (owner !== e.who) begin n_err++; $display("FAIL fetch_owner: got %b want %b", owner, e.who); end
      n_cmp++; if (oreq.valid !== 1'b1) begin n_err++; $display("FAIL fetch_valid: got %b want 1", oreq.valid); end
      n_cmp++; if (oreq.addr !== e.addr) begin n_err++; $display("FAIL fetch_addr: got %h want %h", oreq.addr, e.addr); end
      oresp.data_ok = 1'b1; oresp.data = e.data;
      settle();
      n_cmp++; if (fresp.data_ok !== 1'b1) begin n_err++; $display("FAIL fetch_ok: got %b want 1", fresp.data_ok); end
      n_cmp++; if (fresp.data !== e.data) begin n_err++; $display("FAIL fetch_data: got %h want %h", fresp.data, e.data); end
      n_cmp++; if (mresp !== '0) begin n_err++; $display("FAIL fetch_mresp: got %h want 0", mresp); end
      freq = '0;
      tick(); oresp = '0; settle();
      n_cmp++; if (owner !== 2'b00) begin n_err++; $display("FAIL fetch_done_owner: got %b want 00", owner); end
   endtask

   task automatic test_tie();
      dbus_resp_t win;
      dbus_resp_t lose;
      logic [1:0] who;
      reset = 1'b0; tick(); reset = 1'b1; tick();
      for (int i = 0; i < 3; i++) begin
`ifdef DBUS_ARB_RR_EN
         who = (i == 1) ? 2'b01 : 2'b10;
`else
         who = 2'b10;
`endif
         freq = '0; freq.valid = 1'b1; freq.addr = 32'h8000_2000 + 32'(i * 4);
         mreq = '0; mreq.valid = 1'b1; mreq.addr = 32'h1000_0000 + 32'(i * 16);
         push_exp(who, (who == 2'b01) ? freq.addr : mreq.addr, 32'h0000_00D0 + 32'(i));
         tick(); settle();
         e = exp_q.pop_front();
         n_cmp++; if (owner !== e.who) begin n_err++; $display("FAIL tie%0d_owner: got %b want %b", i, owner, e.who); end
         n_cmp++; if (oreq.addr !== e.addr) begin n_err++; $display("FAIL tie%0d_addr: got %h want %h", i, oreq.addr, e.addr); end
         oresp.data_ok = 1'b1; oresp.data = e.data;
         settle();
         win  = (e.who == 2'b01) ? fresp : mresp;
         lose = (e.who == 2'b01) ? mresp : fresp;
         n_cmp++; if (win.data_ok !== 1'b1 || win.data !== e.data) begin n_err++; $display("FAIL tie%0d_resp: got %b/%h want 1/%h", i, win.data_ok, win.data, e.data); end
         n_cmp++; if (lose.data_ok !== 1'b0) begin n_err++; $display("FAIL tie%0d_loser_ok: got %b want 0", i, lose.data_ok); end
         tick(); oresp = '0;
      end
      mreq = '0;
      push_exp(2'b01, freq.addr, 32'h0000_00F0);
      tick(); settle();
      e = exp_q.pop_front();
      n_cmp++; if (owner !== e.who) begin n_err++; $display("FAIL tie_fetch_owner: got %b want %b", owner, e.who); end
      n_cmp++; if (oreq.addr !== e.addr) begin n_err++; $display("FAIL tie_fetch_addr: got %h want %h", oreq.addr, e.addr); end
      oresp.data_ok = 1'b1; oresp.data = e.data;
      settle();
      n_cmp++; if (fresp.data !== e.data || fresp.data_ok !== 1'b1) begin n_err++; $display("FAIL tie_fetch_resp: got %b/%h want 1/%h", fresp.data_ok, fresp.data, e.data); end
      freq = '0;
      tick(); oresp = '0;
   endtask

   task automatic test_abandon();
      freq = '0; freq.valid = 1'b1; freq.addr = 32'h8000_3000;
      tick(); settle();
      n_cmp++; if (owner !== 2'b01) begin n_err++; $display("FAIL abandon_owner: got %b want 01", owner); end
      freq = '0; freq.addr = 32'h0BAD_0BAD;
      tick(); settle();
      n_cmp++; if (owner !== 2'b00) begin n_err++; $display("FAIL drain_owner: got %b want 00", owner); end
      n_cmp++; if (oreq.valid !== 1'b1 || oreq.addr !== 32'h8000_3000) begin n_err++; $display("FAIL drain_req: got %b/%h want 1/80003000", oreq.valid, oreq.addr); end
      oresp.data_ok = 1'b1; oresp.data = 32'hCAFE_F00D;
      settle();
      n_cmp++; if (fresp.data_ok !== 1'b0) begin n_err++; $display("FAIL drain_fresp_ok: got %b want 0", fresp.data_ok); end
      n_cmp++; if (mresp.data_ok !== 1'b0) begin n_err++; $display("FAIL drain_mresp_ok: got %b want 0", mresp.data_ok); end
      tick(); oresp = '0; settle();
      n_cmp++; if (oreq.valid !== 1'b0) begin n_err++; $display("FAIL drain_exit_valid: got %b want 0", oreq.valid); end
   endtask

   task automatic test_reset_mid();
      mreq = '0; mreq.valid = 1'b1; mreq.addr = 32'h3000_0000;
      tick(); settle();
      n_cmp++; if (owner !== 2'b10) begin n_err++; $display("FAIL rstmid_owner_pre: got %b want 10", owner); end
      reset = 1'b0;
      tick();
      oresp.data_ok = 1'b1; oresp.data = 32'h5555_AAAA;
      settle();
      n_cmp++; if (oreq.valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", oreq.valid); end
      n_cmp++; if (mresp.data_ok !== 1'b0) begin n_err++; $display("FAIL rstmid_mresp_ok: got %b want 0", mresp.data_ok); end
      n_cmp++; if (owner !== 2'b00) begin n_err++; $display("FAIL rstmid_owner: got %b want 00", owner); end
      reset = 1'b1; mreq = '0; oresp = '0;
      tick();
   endtask

   task automatic test_stability();
      mreq = '0; mreq.valid = 1'b1; mreq.addr = 32'h4000_0040;
      push_exp(2'b10, 32'h4000_0040, 32'h7777_0001);
      tick();
      e = exp_q.pop_front();
      mreq.addr = 32'h4000_0080;
      settle();
      n_cmp++; if (oreq.addr !== e.addr) begin n_err++; $display("FAIL stable_addr1: got %h want %h", oreq.addr, e.addr); end
      tick();
      mreq.addr = 32'h4000_00C0;
      settle();
      n_cmp++; if (oreq.addr !== e.addr) begin n_err++; $display("FAIL stable_addr2: got %h want %h", oreq.addr, e.addr); end
      oresp.data_ok = 1'b1; oresp.data = e.data;
      settle();
      n_cmp++; if (mresp.data_ok !== 1'b1 || mresp.data !== e.data) begin n_err++; $display("FAIL stable_resp: got %b/%h want 1/%h", mresp.data_ok, mresp.data, e.data); end
      mreq = '0;
      tick(); oresp = '0;
   endtask

   task automatic test_back_to_back();
      freq = '0; freq.valid = 1'b1; freq.addr = 32'h8000_5000;
      push_exp(2'b01, 32'h8000_5000, 32'h1111_0001);
      tick(); settle();
      e = exp_q.pop_front();
      n_cmp++; if (oreq.addr !== e.addr) begin n_err++; $display("FAIL b2b_addr1: got %h want %h", oreq.addr, e.addr); end
      oresp.data_ok = 1'b1; oresp.data = e.data;
      settle();
      n_cmp++; if (fresp.data !== e.data || fresp.data_ok !== 1'b1) begin n_err++; $display("FAIL b2b_resp1: got %b/%h want 1/%h", fresp.data_ok, fresp.data, e.data); end
      freq.addr = 32'h8000_5004;
      push_exp(2'b01, 32'h8000_5004, 32'h1111_0002);
      tick(); oresp = '0; settle();
      n_cmp++; if (owner !== 2'b00 || oreq.valid !== 1'b0) begin n_err++; $display("FAIL b2b_gap: got %b/%b want 00/0", owner, oreq.valid); end
      tick(); settle();
      e = exp_q.pop_front();
      n_cmp++; if (owner !== e.who || oreq.addr !== e.addr) begin n_err++; $display("FAIL b2b_grant2: got %b/%h want %b/%h", owner, oreq.addr, e.who, e.addr); end
      oresp.data_ok = 1'b1; oresp.data = e.data;
      settle();
      n_cmp++; if (fresp.data !== e.data || fresp.data_ok !== 1'b1) begin n_err++; $display("FAIL b2b_resp2: got %b/%h want 1/%h", fresp.data_ok, fresp.data, e.data); end
      freq = '0;
      tick(); oresp = '0;
   endtask

   initial begin
      reset = 1'b0; freq = '0; mreq = '0; oresp = '0;
      tick();
      test_reset();
      test_fetch_only();
      test_tie();
      test_abandon();
      test_reset_mid();
      test_stability();
      test_back_to_back();
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
